// File: rtl/sram_1w1r_param_bypass.sv
// rtl/sram_1w1r_param_bypass.sv - parametrised 1W1R masked-write SRAM model with read pipeline and bypass
//
// Ports:
//   clk0        single clock, rising edge
//   rst0        asynchronous active-high reset
//   csb0        write select, active low
//   wmask0      per-lane write enable, bit i covers din0[i*WRITE_SIZE +: WRITE_SIZE]
//   addr0       write address
//   din0        write data
//   csb1        read select, active low
//   addr1       read address
//   dout1       read data, holds the last completed read
//   dout1_valid one-cycle pulse per completed read
//   collision1  same-address write seen on the read's request edge (qualified by dout1_valid)
//   oor1        read address was >= RAM_DEPTH (qualified by dout1_valid)
module sram_1w1r_param_bypass #(
  parameter int DATA_WIDTH   = 120,
  parameter int WRITE_SIZE   = 30,
  parameter int NUM_WMASKS   = DATA_WIDTH / WRITE_SIZE,
  parameter int ADDR_WIDTH   = 7,
  parameter int RAM_DEPTH    = 1 << ADDR_WIDTH,
  parameter int READ_LATENCY = 1,
  parameter bit BYPASS       = 1'b1
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  csb0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic                  collision1,
  output logic                  oor1
);

  if (DATA_WIDTH % WRITE_SIZE != 0) begin : g_err_lane
    $error("DATA_WIDTH must be a multiple of WRITE_SIZE");
  end
  if (NUM_WMASKS != DATA_WIDTH / WRITE_SIZE) begin : g_err_nmask
    $error("NUM_WMASKS is derived and must equal DATA_WIDTH/WRITE_SIZE");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_err_lat
    $error("READ_LATENCY must be in 1..4");
  end
  if (RAM_DEPTH < 1 || RAM_DEPTH > (1 << ADDR_WIDTH)) begin : g_err_depth
    $error("RAM_DEPTH must be in 1..2^ADDR_WIDTH");
  end

  // One extra bit so RAM_DEPTH == 2^ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(RAM_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem     [RAM_DEPTH];
  logic [NUM_WMASKS-1:0] r_written [RAM_DEPTH];

  logic [DATA_WIDTH-1:0]   r_pipe_data [READ_LATENCY];
  logic [READ_LATENCY-1:0] r_pipe_valid;
  logic [READ_LATENCY-1:0] r_pipe_col;
  logic [READ_LATENCY-1:0] r_pipe_oor;

  logic                  w_wr_in_range;
  logic                  w_rd_oor;
  logic                  w_same_addr;
  logic                  w_collision;
  logic [DATA_WIDTH-1:0] w_rd_word;

  assign w_wr_in_range = ({1'b0, addr0} < DEPTH_LIMIT);
  assign w_rd_oor      = !({1'b0, addr1} < DEPTH_LIMIT);
  assign w_same_addr   = !csb0 && (addr0 == addr1);
  assign w_collision   = w_same_addr && (|wmask0);

  // Stage-0 read word: unwritten lanes read as zero; with BYPASS the lanes
  // being written on this edge are forwarded from din0 (write-first).
  always_comb begin
    w_rd_word = '0;
    if (!w_rd_oor) begin
      for (int i = 0; i < NUM_WMASKS; i++) begin
        if (BYPASS && w_same_addr && wmask0[i]) begin
          w_rd_word[i*WRITE_SIZE +: WRITE_SIZE] = din0[i*WRITE_SIZE +: WRITE_SIZE];
        end else if (r_written[addr1][i]) begin
          w_rd_word[i*WRITE_SIZE +: WRITE_SIZE] = r_mem[addr1][i*WRITE_SIZE +: WRITE_SIZE];
        end
      end
    end
  end

  // Array contents are never reset; visibility is governed by r_written.
  always_ff @(posedge clk0) begin
    if (!rst0 && !csb0 && w_wr_in_range) begin
      for (int i = 0; i < NUM_WMASKS; i++) begin
        if (wmask0[i]) begin
          r_mem[addr0][i*WRITE_SIZE +: WRITE_SIZE] <= din0[i*WRITE_SIZE +: WRITE_SIZE];
        end
      end
    end
  end

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      for (int w = 0; w < RAM_DEPTH; w++) begin
        r_written[w] <= '0;
      end
    end else if (!csb0 && w_wr_in_range) begin
      r_written[addr0] <= r_written[addr0] | wmask0;
    end
  end

  // Data registers only load on a valid beat so the last stage keeps the
  // most recent completed read while idle; flag bits are cleared when idle.
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      for (int s = 0; s < READ_LATENCY; s++) begin
        r_pipe_data[s] <= '0;
      end
      r_pipe_valid <= '0;
      r_pipe_col   <= '0;
      r_pipe_oor   <= '0;
    end else begin
      r_pipe_valid[0] <= !csb1;
      r_pipe_col[0]   <= !csb1 && w_collision;
      r_pipe_oor[0]   <= !csb1 && w_rd_oor;
      if (!csb1) begin
        r_pipe_data[0] <= w_rd_word;
      end
      for (int s = 1; s < READ_LATENCY; s++) begin
        r_pipe_valid[s] <= r_pipe_valid[s-1];
        r_pipe_col[s]   <= r_pipe_col[s-1];
        r_pipe_oor[s]   <= r_pipe_oor[s-1];
        if (r_pipe_valid[s-1]) begin
          r_pipe_data[s] <= r_pipe_data[s-1];
        end
      end
    end
  end

  assign dout1       = r_pipe_data[READ_LATENCY-1];
  assign dout1_valid = r_pipe_valid[READ_LATENCY-1];
  assign collision1  = r_pipe_col[READ_LATENCY-1];
  assign oor1        = r_pipe_oor[READ_LATENCY-1];

endmodule

// File: tb/tb_sram_1w1r_param_bypass.sv
// tb/tb_sram_1w1r_param_bypass.sv - self-checking bench for sram_1w1r_param_bypass
module tb_sram_1w1r_param_bypass;

  localparam int DW = 120;
  localparam int WS = 30;
  localparam int NW = 4;
  localparam int AW = 7;
  localparam logic [DW-1:0] ONES = {DW{1'b1}};

  logic          clk0 = 1'b0;
  logic          rst0 = 1'b0;
  logic          csb0 = 1'b1;
  logic [NW-1:0] wmask0 = '0;
  logic [AW-1:0] addr0 = '0;
  logic [DW-1:0] din0 = '0;
  logic          csb1 = 1'b1;
  logic [AW-1:0] addr1 = '0;

  logic [DW-1:0] o_d [3];
  logic [2:0]    o_v, o_c, o_o;

  always #5 clk0 = ~clk0;

  sram_1w1r_param_bypass #(.DATA_WIDTH(DW), .WRITE_SIZE(WS), .ADDR_WIDTH(AW),
    .RAM_DEPTH(100), .READ_LATENCY(1), .BYPASS(1'b1)) u_d0 (
    .clk0(clk0), .rst0(rst0), .csb0(csb0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .csb1(csb1), .addr1(addr1), .dout1(o_d[0]), .dout1_valid(o_v[0]),
    .collision1(o_c[0]), .oor1(o_o[0]));

  sram_1w1r_param_bypass #(.DATA_WIDTH(DW), .WRITE_SIZE(WS), .ADDR_WIDTH(AW),
    .RAM_DEPTH(100), .READ_LATENCY(3), .BYPASS(1'b0)) u_d1 (
    .clk0(clk0), .rst0(rst0), .csb0(csb0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .csb1(csb1), .addr1(addr1), .dout1(o_d[1]), .dout1_valid(o_v[1]),
    .collision1(o_c[1]), .oor1(o_o[1]));

  sram_1w1r_param_bypass #(.DATA_WIDTH(DW), .WRITE_SIZE(WS), .ADDR_WIDTH(AW),
    .RAM_DEPTH(128), .READ_LATENCY(2), .BYPASS(1'b1)) u_d2 (
    .clk0(clk0), .rst0(rst0), .csb0(csb0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .csb1(csb1), .addr1(addr1), .dout1(o_d[2]), .dout1_valid(o_v[2]),
    .collision1(o_c[2]), .oor1(o_o[2]));

  int depth_k [3] = '{100, 100, 128};
  int rl_k    [3] = '{1, 3, 2};
  bit byp_k   [3] = '{1'b1, 1'b0, 1'b1};

  // Reference: per-instance word/lane-written arrays, plus a scoreboard of
  // expected completions keyed by the cycle on which they must appear.
  logic [DW-1:0] m_mem  [3][128];
  logic [NW-1:0] m_wr   [3][128];
  bit            e_v    [3][8];
  logic [DW-1:0] e_d    [3][8];
  bit            e_c    [3][8];
  bit            e_o    [3][8];
  logic [DW-1:0] last_d [3];
  int            cyc;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int a = 0; a < 128; a++) m_wr[k][a] = '0;
      for (int s = 0; s < 8; s++) e_v[k][s] = 1'b0;
      last_d[k] = '0;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s d%0d valid", tag, k), DW'(o_v[k]), '0);
      chk($sformatf("%s d%0d dout", tag, k), o_d[k], '0);
      chk($sformatf("%s d%0d col", tag, k), DW'(o_c[k]), '0);
      chk($sformatf("%s d%0d oor", tag, k), DW'(o_o[k]), '0);
    end
  endtask

  task automatic step(input logic c0, input logic [NW-1:0] wm, input logic [AW-1:0] a0,
                      input logic [DW-1:0] d, input logic c1, input logic [AW-1:0] a1);
    logic [DW-1:0] word;
    bit            col, oor;
    int            slot;
    csb0 = c0; wmask0 = wm; addr0 = a0; din0 = d; csb1 = c1; addr1 = a1;
    for (int k = 0; k < 3; k++) begin
      if (!c1) begin
        oor  = (int'(a1) >= depth_k[k]);
        col  = !c0 && (a0 == a1) && (wm != 0);
        word = '0;
        if (!oor) begin
          for (int i = 0; i < NW; i++) begin
            if (byp_k[k] && !c0 && a0 == a1 && wm[i])
              word[i*WS +: WS] = d[i*WS +: WS];
            else if (m_wr[k][a1][i])
              word[i*WS +: WS] = m_mem[k][a1][i*WS +: WS];
          end
        end
        slot = (cyc + rl_k[k]) % 8;
        e_v[k][slot] = 1'b1; e_d[k][slot] = word; e_c[k][slot] = col; e_o[k][slot] = oor;
      end
    end
    for (int k = 0; k < 3; k++) begin
      if (!c0 && int'(a0) < depth_k[k]) begin
        for (int i = 0; i < NW; i++) begin
          if (wm[i]) begin
            m_mem[k][a0][i*WS +: WS] = d[i*WS +: WS];
            m_wr[k][a0][i] = 1'b1;
          end
        end
      end
    end
    @(posedge clk0);
    #1;
    cyc++;
    for (int k = 0; k < 3; k++) begin
      slot = cyc % 8;
      if (e_v[k][slot]) begin
        chk($sformatf("cyc%0d d%0d valid", cyc, k), DW'(o_v[k]), DW'(1));
        chk($sformatf("cyc%0d d%0d dout", cyc, k), o_d[k], e_d[k][slot]);
        chk($sformatf("cyc%0d d%0d col", cyc, k), DW'(o_c[k]), DW'(e_c[k][slot]));
        chk($sformatf("cyc%0d d%0d oor", cyc, k), DW'(o_o[k]), DW'(e_o[k][slot]));
        last_d[k] = e_d[k][slot];
        e_v[k][slot] = 1'b0;
      end else begin
        chk($sformatf("cyc%0d d%0d idle valid", cyc, k), DW'(o_v[k]), '0);
        chk($sformatf("cyc%0d d%0d idle dout", cyc, k), o_d[k], last_d[k]);
        chk($sformatf("cyc%0d d%0d idle col", cyc, k), DW'(o_c[k]), '0);
        chk($sformatf("cyc%0d d%0d idle oor", cyc, k), DW'(o_o[k]), '0);
      end
    end
  endtask

  task automatic idle();
    step(1'b1, '0, '0, '0, 1'b1, '0);
  endtask

  typedef struct {
    logic          c0;
    logic [NW-1:0] wm;
    logic [AW-1:0] a0;
    logic [DW-1:0] d;
    logic          c1;
    logic [AW-1:0] a1;
    logic          ev;
    logic [DW-1:0] ed;
    logic          ec;
    logic          eo;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic [DW-1:0] p2, e2, e3, la, lb, lc, ln;
    logic [127:0]  rnd;
    logic [AW-1:0] ra0, ra1;

    p2 = {30'h3AAAAAAA, 30'h15555555, 30'h0F0F0F0F, 30'h00000001};
    e2 = {30'h00000000, 30'h15555555, 30'h00000000, 30'h00000001};
    e3 = {30'h3FFFFFFF, 30'h3FFFFFFF, 30'h00000000, 30'h00000000};
    la = {4{30'h01234567}};
    lb = {4{30'h0ABCDEF0}};
    lc = {4{30'h13572468}};
    ln = {4{30'h2468ACE0}};

    // Expectations below are for u_d0 (latency 1, write-first, depth 100).
    tbl[0]  = '{1'b1, 4'h0, 7'd0,   '0,   1'b0, 7'd5,   1'b1, '0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 4'h5, 7'd3,   p2,   1'b1, 7'd0,   1'b0, '0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 4'h0, 7'd0,   '0,   1'b0, 7'd3,   1'b1, e2, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 4'hF, 7'd7,   ONES, 1'b1, 7'd0,   1'b0, e2, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 4'h3, 7'd7,   '0,   1'b0, 7'd7,   1'b1, e3, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 4'h0, 7'd5,   ONES, 1'b1, 7'd0,   1'b0, e3, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 4'h0, 7'd0,   '0,   1'b0, 7'd5,   1'b1, '0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 4'hF, 7'd120, ONES, 1'b1, 7'd0,   1'b0, '0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 4'h0, 7'd0,   '0,   1'b0, 7'd120, 1'b1, '0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 4'h0, 7'd0,   '0,   1'b0, 7'd99,  1'b1, '0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 4'h0, 7'd0,   '0,   1'b0, 7'd7,   1'b1, e3, 1'b0, 1'b0};

    cyc = 0;
    for (int k = 0; k < 3; k++)
      for (int a = 0; a < 128; a++) m_mem[k][a] = '0;
    model_reset();

    #2 rst0 = 1'b1;
    #1 check_outputs_zero("reset");
    @(posedge clk0);
    #1 rst0 = 1'b0;
    cyc = 1;

    for (int r = 0; r < 11; r++) begin
      step(tbl[r].c0, tbl[r].wm, tbl[r].a0, tbl[r].d, tbl[r].c1, tbl[r].a1);
      chk($sformatf("tbl%0d valid", r), DW'(o_v[0]), DW'(tbl[r].ev));
      chk($sformatf("tbl%0d dout", r), o_d[0], tbl[r].ed);
      chk($sformatf("tbl%0d col", r), DW'(o_c[0]), DW'(tbl[r].ec));
      chk($sformatf("tbl%0d oor", r), DW'(o_o[0]), DW'(tbl[r].eo));
    end

    // Latency-3 in-order delivery on u_d1; writes to addr 1 on and after its read edge.
    step(1'b0, 4'hF, 7'd0, la, 1'b1, '0);
    step(1'b0, 4'hF, 7'd1, lb, 1'b1, '0);
    step(1'b0, 4'hF, 7'd2, lc, 1'b1, '0);
    idle(); idle(); idle();
    step(1'b1, 4'h0, 7'd0, '0, 1'b0, 7'd0);
    chk("lat e1 valid", DW'(o_v[1]), '0);
    step(1'b0, 4'hF, 7'd1, ln, 1'b0, 7'd1);
    chk("lat e2 valid", DW'(o_v[1]), '0);
    step(1'b0, 4'hF, 7'd1, ln, 1'b0, 7'd2);
    chk("lat e3 valid", DW'(o_v[1]), DW'(1));
    chk("lat e3 dout", o_d[1], la);
    idle();
    chk("lat e4 valid", DW'(o_v[1]), DW'(1));
    chk("lat e4 dout", o_d[1], lb);
    idle();
    chk("lat e5 valid", DW'(o_v[1]), DW'(1));
    chk("lat e5 dout", o_d[1], lc);
    idle();
    chk("lat e6 valid", DW'(o_v[1]), '0);
    chk("lat e6 hold", o_d[1], lc);

    // Read-first collision on u_d1.
    step(1'b0, 4'hF, 7'd8, ONES, 1'b1, '0);
    step(1'b0, 4'h3, 7'd8, '0, 1'b0, 7'd8);
    idle(); idle();
    chk("rf col valid", DW'(o_v[1]), DW'(1));
    chk("rf col dout", o_d[1], ONES);
    chk("rf col flag", DW'(o_c[1]), DW'(1));

    for (int n = 0; n < 400; n++) begin
      ra0 = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(94, 105)) : AW'($urandom_range(0, 127));
      ra1 = ($urandom_range(0, 2) == 0) ? ra0 : AW'($urandom_range(94, 105));
      rnd = {$urandom, $urandom, $urandom, $urandom};
      step(1'(($urandom_range(0, 2) == 0)), NW'($urandom_range(0, 15)), ra0, rnd[DW-1:0],
           1'(($urandom_range(0, 3) == 0)), ra1);
    end

    // Asynchronous reset with reads in flight; a write held during reset must not land.
    step(1'b1, 4'h0, 7'd0, '0, 1'b0, 7'd3);
    #2 rst0 = 1'b1;
    #1 check_outputs_zero("midreset");
    model_reset();
    csb0 = 1'b0; wmask0 = 4'hF; addr0 = 7'd50; din0 = ONES; csb1 = 1'b1;
    @(posedge clk0);
    #1 cyc++;
    check_outputs_zero("inreset");
    #2 rst0 = 1'b0;
    idle(); idle(); idle(); idle();
    step(1'b1, 4'h0, 7'd0, '0, 1'b0, 7'd50);
    chk("post reset read50 valid", DW'(o_v[0]), DW'(1));
    chk("post reset read50 dout", o_d[0], '0);
    idle(); idle(); idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_1w1r_param_bypass.md
Name: sram_1w1r_param_bypass

Overview:
- Parametrised, single-clock successor to the team's OpenRAM-style 1W1R masked-write SRAM models; synthesisable behavioural model for FreePDK45 macro slots.
- Adds the following over the current models:
  - configurable depth (including non-power-of-two) and mask granularity;
  - read latency pipeline;
  - selectable write-first bypass;
  - per-lane written tracking, so unwritten lanes read as zero instead of X;
  - out-of-range and collision flags.
- Sits between the cache/buffer controllers and the physical macro footprint.

Parameters:
- DATA_WIDTH, 120, bits per word.
- WRITE_SIZE, 30, bits per write-mask lane. DATA_WIDTH must be a multiple of WRITE_SIZE.
- NUM_WMASKS, DATA_WIDTH/WRITE_SIZE, derived; do not override.
- ADDR_WIDTH, 7, address bits.
- RAM_DEPTH, 1<<ADDR_WIDTH, number of words. Legal range is 1..2^ADDR_WIDTH.
- READ_LATENCY, 1, cycles from read request to dout1 valid. Legal range is 1..4.
- BYPASS, 1. 1 = write-first forwarding on same-address read/write; 0 = read-first (old data).

Ports:
- clk0  input  1  the only clock; all state is updated on the rising edge.
- rst0  input  1  asynchronous, active-high reset.
- csb0  input  1  write port select, active low.
- wmask0  input  NUM_WMASKS  per-lane write enable; bit i covers din0[i*WRITE_SIZE +: WRITE_SIZE].
- addr0  input  ADDR_WIDTH  write address.
- din0  input  DATA_WIDTH  write data.
- csb1  input  1  read port select, active low.
- addr1  input  ADDR_WIDTH  read address.
- dout1  output  DATA_WIDTH  read data.
- dout1_valid  output  1  one-cycle pulse per completed read.
- collision1  output  1  qualifies dout1_valid; same-address read and write occurred in the same cycle.
- oor1  output  1  qualifies dout1_valid; the read address was >= RAM_DEPTH.

Behaviour:
- Reset (rst0=1, asynchronous):
  - clears every per-word/per-lane written bit and all read pipeline stages;
  - dout1=0, dout1_valid=0, collision1=0, oor1=0;
  - array contents are not cleared, but are unobservable because written bits are 0;
  - in-flight reads are dropped and produce no valid pulse after reset deasserts;
  - writes presented while rst0=1 are ignored.
- Write, on posedge when csb0=0:
  - for each lane i with wmask0[i]=1: mem[addr0] lane i <= din0 lane i and written[addr0][i] <= 1;
  - lanes with wmask0[i]=0 are untouched;
  - wmask0=0 is a no-op;
  - addr0 >= RAM_DEPTH is silently dropped.
- Read, on posedge when csb1=0, stage 0 captures a data word:
  - each lane is mem[addr1] lane i if written[addr1][i]=1, else 0;
  - if BYPASS=1, csb0=0, addr0==addr1 and wmask0[i]=1, lane i takes din0 lane i instead (write-first);
  - if BYPASS=0, the array value from before this edge is used (read-first);
  - collision bit = (csb0=0 && addr0==addr1 && |wmask0), independent of BYPASS;
  - oor bit = (addr1 >= RAM_DEPTH); an out-of-range read returns all-zero data.
- Pipeline:
  - the captured word, collision and oor bits travel READ_LATENCY-1 further register stages;
  - dout1/collision1/oor1 update and dout1_valid=1 exactly READ_LATENCY cycles after the request edge;
  - back-to-back reads are accepted every cycle, full throughput, no stall;
  - writes after the request edge never alter an in-flight read.
- Idle:
  - dout1 holds the last valid data (never X) when no read completes;
  - collision1/oor1 read 0 whenever dout1_valid=0.
- Elaboration checks: $error if DATA_WIDTH % WRITE_SIZE != 0, READ_LATENCY is outside 1..4, or RAM_DEPTH > 2^ADDR_WIDTH.

Test Plan:
1. Reset then read: rst0 pulse; read addr 5 → after 1 cycle dout1=0, dout1_valid=1, collision1=0, oor1=0.
2. Masked write: write addr 3, din0 lanes {3,2,1,0} = {0x3AAAAAAA,0x15555555,0x0F0F0F0F,0x00000001}, wmask0=4'b0101; then read addr 3 → lane0=0x00000001, lane2=0x15555555, lanes 1 and 3 = 0.
3. Collision with BYPASS=1: addr 7 holds all-ones; same edge write addr 7 din0=0, wmask0=4'b0011, and read addr 7 → dout1 lanes0-1=0, lanes2-3 all-ones, collision1=1. Repeat with BYPASS=0 → dout1 all-ones, collision1=1.
4. Latency: READ_LATENCY=3; reads of addr 0,1,2 on consecutive edges (distinct known data) → dout1_valid high on edges 3,4,5 with matching data in order; a write to addr 1 on edge 1 does not change the edge-4 result.
5. Out of range: RAM_DEPTH=100; write addr 120 wmask0=4'hF din0=all-ones, then read addr 120 → dout1=0, oor1=1; read addr 99 → oor1=0.
6. Reset mid-read: READ_LATENCY=2; read issued, rst0 asserted asynchronously between edges → dout1_valid stays 0; outputs are 0 immediately; no late pulse after release.
